adc_mixer: RTL

- Parametrised N-channel ADC mixer: each signed ADC input is scaled by a per-channel signed gain, the scaled inputs are summed, and the result is saturated to the output width.
- Gains are written over the serial setting bus into shadow registers and applied atomically at the start of each sample.
- One shared multiplier is time-multiplexed across channels by a small FSM.
- Sits between the ADC capture logic and the MRFM feedback/DDC path, and generalises the fixed two-channel on/off switch.

---
 rtl/adc_mixer_if.sv | 27 ++
 rtl/adc_mixer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adc_mixer_if.sv
// Port bundle for adc_mixer: setting bus, sample input and mix output.
// The master drives the settings and samples; the slave is the mixer itself.
interface adc_mixer_if #(
    parameter int NCH   = 4,
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
);
    logic [6:0]          serial_addr;
    logic [31:0]         serial_data;
    logic                serial_strobe;
    logic [NCH*IN_W-1:0] in_data;
    logic                in_strobe;
    logic                ready;
    logic [OUT_W-1:0]    sum;
    logic                out_strobe;
    logic                overrun;

    modport master (
        output serial_addr, serial_data, serial_strobe, in_data, in_strobe,
        input  ready, sum, out_strobe, overrun
    );

    modport slave (
        input  serial_addr, serial_data, serial_strobe, in_data, in_strobe,
        output ready, sum, out_strobe, overrun
    );
endinterface

// File: rtl/adc_mixer.sv
// N-channel ADC mixer: each signed sample is scaled by its own signed gain,
// the products are summed at full precision and the result is saturated.
// A single multiplier is shared across channels, one channel per cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a sample; ready=1
// S_ACC  | one multiply-accumulate per cycle, channel 0..NCH-1; ready=0
// S_DONE | publish saturated result next edge; a new sample may be accepted
module adc_mixer #(
    parameter int         NCH       = 4,
    parameter int         IN_W      = 12,
    parameter int         OUT_W     = 16,
    parameter int         K_W       = 16,
    parameter logic [6:0] BASE_ADDR = 7'd64
) (
    input  logic       clock,
    input  logic       reset,
    adc_mixer_if.slave bus
);
    localparam int CH_W   = $clog2(NCH);
    localparam int PROD_W = IN_W + K_W;
    localparam int ACC_W  = PROD_W + $clog2(NCH);
    localparam int SH     = K_W - 2 - (OUT_W - IN_W);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CH_W-1:0]         CH_LAST = CH_W'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_ready;
    logic [CH_W-1:0]          r_ch;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [IN_W-1:0]   r_samp   [NCH];
    logic signed [K_W-1:0]    r_active [NCH];
    logic signed [K_W-1:0]    r_shadow [NCH];
    logic [OUT_W-1:0]         r_sum;
    logic                     r_out_strobe;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_drop;
    logic                     w_clear;
    logic signed [IN_W-1:0]   w_mul_a;
    logic signed [K_W-1:0]    w_mul_b;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_shift;
    logic [OUT_W-1:0]         w_sat;
    logic                     w_unused_data;

    // Only ACC is busy; a strobe there is lost and flagged instead of queued.
    assign w_accept = bus.in_strobe && (r_state != S_ACC);
    assign w_drop   = bus.in_strobe && (r_state == S_ACC);
    assign w_clear  = bus.serial_strobe && (bus.serial_addr == BASE_ADDR + 7'(NCH));

    assign w_mul_a    = r_samp[r_ch];
    assign w_mul_b    = r_active[r_ch];
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_shift    = r_acc >>> SH;

    // Upper setting-bus bits beyond the gain width carry no meaning here.
    assign w_unused_data = ^{1'b0, bus.serial_data};

    // Clamp the scaled accumulator into the signed output range.
    always_comb begin
        w_sat = w_shift[OUT_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // Sequencer: sample/gain capture, shared MAC, and result publication.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_ch         <= '0;
            r_acc        <= '0;
            r_sum        <= '0;
            r_out_strobe <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_samp[i]   <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_out_strobe <= 1'b0;
            // Gains are snapshotted with the samples so a mid-sample write
            // cannot mix old and new coefficients within one result.
            if (w_accept) begin
                for (int i = 0; i < NCH; i++) begin
                    r_samp[i]   <= bus.in_data[i*IN_W +: IN_W];
                    r_active[i] <= r_shadow[i];
                end
                r_acc <= '0;
                r_ch  <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.in_strobe) begin
                        r_state <= S_ACC;
                        r_ready <= 1'b0;
                    end
                end
                S_ACC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_ch == CH_LAST) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                S_DONE: begin
                    r_sum        <= w_sat;
                    r_out_strobe <= 1'b1;
                    if (bus.in_strobe) begin
                        r_state <= S_ACC;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Shadow gain registers written from the setting bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (bus.serial_strobe) begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.serial_addr == BASE_ADDR + 7'(i)) begin
                    r_shadow[i] <= bus.serial_data[K_W-1:0];
                end
            end
        end
    end

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (w_clear) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.ready      = r_ready;
    assign bus.sum        = r_sum;
    assign bus.out_strobe = r_out_strobe;
    assign bus.overrun    = r_overrun;
endmodule
